gray_codec_pipe: RTL and testbench
==================================

GRAY_CODEC_PIPE -- requirements
Module: gray_codec_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the bit width of one channel word (2..32).
REQ-002 SHALL have parameter CHANNELS, default 1, meaning the number of independent lanes packed LSB-first (1..8).
REQ-003 SHALL have parameter MODE, default "B2G", meaning the conversion direction: "B2G" (binary to gray) or "G2B" (gray to binary).
REQ-004 SHALL have parameter RESET_VALUE, default 0, meaning the per-channel output word loaded at reset.
REQ-005 SHALL have port clk, input, 1 bit, meaning the single clock; all logic is on the rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit, meaning the synchronous active-low reset.
REQ-007 SHALL have port i_valid, input, 1 bit, meaning iv_data is valid.
REQ-008 SHALL have port o_ready, output, 1 bit, meaning the block accepts a word this cycle.
REQ-009 SHALL have port iv_data, input, CHANNELS*DATA_WIDTH bits, meaning the input words.
REQ-010 SHALL have port o_valid, output, 1 bit, meaning ov_data is valid.
REQ-011 SHALL have port i_ready, input, 1 bit, meaning the downstream consumer accepts ov_data.
REQ-012 SHALL have port ov_data, output, CHANNELS*DATA_WIDTH bits, meaning the converted words.
REQ-013 SHALL have port ov_err, output, CHANNELS bits, meaning a sticky per-channel step error (present only with GRAY_CODEC_CHECK_EN).

Function
REQ-014 SHALL transfer data in on i_valid&&o_ready and out on o_valid&&i_ready.
REQ-015 SHALL be a 2-stage pipeline (S1 input register, S2 conversion/output register), with latency exactly 2 cycles from accept to o_valid when unstalled.
REQ-016 SHALL support full throughput (one word per cycle) while i_ready=1.
REQ-017 SHALL drive o_ready = !s1_valid || !s2_valid || i_ready, so that pipeline bubbles collapse under backpressure.
REQ-018 SHALL hold ov_data/o_valid stable while o_valid=1 and i_ready=0.
REQ-019 SHALL, in B2G mode, compute per channel g[W-1]=b[W-1] and g[j]=b[j]^b[j+1].
REQ-020 SHALL, in G2B mode, compute per channel b[W-1]=g[W-1] and b[j]=b[j+1]^g[j] (prefix XOR, MSB down).
REQ-021 SHALL process channels independently, so that no bit of channel k affects channel m≠k.
REQ-022 SHALL, on simultaneous S2 drain and S1 fill in one cycle, lose and duplicate no word.
REQ-023 SHALL treat any MODE other than "B2G"/"G2B" as an elaboration error.

Reset
REQ-024 SHALL, while reset_n=0 at a clock edge, clear s1_valid and o_valid, load ov_data with RESET_VALUE replicated per channel, and clear ov_err.
REQ-025 SHALL drive o_ready=1 in the first cycle after reset release.
REQ-026 SHALL, on reset asserted mid-transfer, discard in-flight words with no output handshake.

Configuration
REQ-027 SHALL, with GRAY_CODEC_CHECK_EN defined, check each consecutive accepted gray word per channel (the input in G2B, the output in B2G) and set the sticky ov_err[k] when the Hamming distance from the previous word is >1.
REQ-028 SHALL, with GRAY_CODEC_CHECK_EN defined, skip the comparison for the first word after reset, and treat an equal word as no error.
REQ-029 SHALL, without GRAY_CODEC_CHECK_EN, omit the ov_err port and the history registers entirely.

Structure
REQ-030 SHALL place the MODE string constants, the b2g/g2b conversion functions and the onehot-or-zero check function in shared package gray_codec_pkg.
REQ-031 SHALL implement one sub-module, gray_codec_lane, holding the per-channel conversion and step checker, instantiated CHANNELS times in a generate loop.

Verification
REQ-032 SHALL cover: B2G, W=8, C=1, input 0x00..0xFF continuous with i_ready=1 -> outputs 0x00,0x01,0x03,0x02,... appear 2 cycles after each input, one per cycle.
REQ-033 SHALL cover: G2B, W=4, C=2, input {0xC,0x8} -> ov_data={0x8,0xF}; a round trip through B2G then G2B returns the original words.
REQ-034 SHALL cover: i_ready held 0 for 5 cycles with i_valid=1 -> o_ready falls after 2 words are accepted, ov_data is unchanged, and all words emerge in order on release with none lost.
REQ-035 SHALL cover: reset_n=0 for 1 cycle with 2 words in flight, RESET_VALUE=0x5A -> o_valid=0, ov_data=0x5A, o_ready=1 next cycle, and no stale word emitted.
REQ-036 SHALL cover: GRAY_CODEC_CHECK_EN, G2B, channel 0 gray inputs 0x0,0x1,0x3,0x0 -> ov_err[0] set after the 4th accept and held until reset, while ov_err[1] stays 0.
REQ-037 SHALL cover: random valid/ready toggling for 10k cycles, with a scoreboard checking order, conversion and zero loss on all channels.

Source files
------------

// File: rtl/gray_codec_pkg.sv
// gray_codec_pkg -- shared constants and helpers for the gray code pipeline.
// Holds the MODE selector strings, the binary<->gray conversion functions and
// the onehot-or-zero test used by the optional step checker
// (enabled by defining GRAY_CODEC_CHECK_EN).
package gray_codec_pkg;

  // MODE selector strings; three characters each, so 24 bits wide.
  localparam logic [23:0] MODE_B2G = "B2G";
  localparam logic [23:0] MODE_G2B = "G2B";

  // Widest channel word the helpers below handle.
  localparam int MAX_WIDTH = 32;

  // Binary to gray: every bit is XORed with its upper neighbour and the MSB
  // passes through. Narrow words are zero-extended, so the result holds for
  // any width up to MAX_WIDTH.
  function automatic logic [MAX_WIDTH-1:0] bin_to_gray(
    input logic [MAX_WIDTH-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: a prefix XOR that runs from the MSB down. The zero
  // extension above a narrow word leaves the result unchanged.
  function automatic logic [MAX_WIDTH-1:0] gray_to_bin(
    input logic [MAX_WIDTH-1:0] g
  );
    logic [MAX_WIDTH-1:0] b;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int j = MAX_WIDTH - 2; j >= 0; j--) begin
      b[j] = b[j+1] ^ g[j];
    end
    return b;
  endfunction

  // True when at most one bit is set, i.e. Hamming distance <= 1 for an XOR.
  function automatic logic onehot_or_zero(input logic [MAX_WIDTH-1:0] x);
    return (x & (x - MAX_WIDTH'(1))) == '0;
  endfunction

endpackage : gray_codec_pkg

// File: rtl/gray_codec_lane.sv
// gray_codec_lane -- one channel of the gray code pipeline.
// The conversion is combinational and sits between the S1 and S2 registers
// of the top level. With GRAY_CODEC_CHECK_EN defined, the lane also tracks
// the last accepted gray word and raises a sticky error when two consecutive
// words differ in more than one bit.
module gray_codec_lane
  import gray_codec_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter     MODE       = "B2G"
) (
`ifdef GRAY_CODEC_CHECK_EN
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  accept,
  input  logic [DATA_WIDTH-1:0] in_word,
  output logic                  err,
`endif
  input  logic [DATA_WIDTH-1:0] s1_word,
  output logic [DATA_WIDTH-1:0] conv_word
);

  localparam bit IS_G2B = (MODE == MODE_G2B);

  // Convert the S1 word in the configured direction.
  // NOTE: combinational blocks use blocking '=' and assign every output on
  // every path, so no latch is inferred; clocked blocks use '<=' only.
  always_comb begin
    if (IS_G2B) begin
      conv_word = DATA_WIDTH'(gray_to_bin(MAX_WIDTH'(s1_word)));
    end else begin
      conv_word = DATA_WIDTH'(bin_to_gray(MAX_WIDTH'(s1_word)));
    end
  end

`ifdef GRAY_CODEC_CHECK_EN
  logic [DATA_WIDTH-1:0] gray_word;
  logic [DATA_WIDTH-1:0] prev_word;
  logic                  have_prev;

  // Pick the gray-coded side of the accepted word. In G2B mode that is the
  // input; in B2G mode it is the output the word will produce.
  always_comb begin
    if (IS_G2B) begin
      gray_word = in_word;
    end else begin
      gray_word = DATA_WIDTH'(bin_to_gray(MAX_WIDTH'(in_word)));
    end
  end

  // Record each accepted gray word and latch an error on a multi-bit step.
  // The first word after reset only seeds the history.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      have_prev <= 1'b0;
      prev_word <= '0;
      err       <= 1'b0;
    end else if (accept) begin
      have_prev <= 1'b1;
      prev_word <= gray_word;
      if (have_prev && !onehot_or_zero(MAX_WIDTH'(prev_word ^ gray_word))) begin
        err <= 1'b1;
      end
    end
  end
`endif

endmodule : gray_codec_lane

// File: rtl/gray_codec_pipe.sv
// gray_codec_pipe -- two-stage valid/ready pipeline that converts CHANNELS
// packed words (LSB-first) between binary and gray code.
// S1 registers the accepted input. S2 registers the converted result and
// drives the output. Backpressure lets a bubble in either stage be filled,
// so the pipeline holds two words when the consumer stalls.
// Optional feature: define GRAY_CODEC_CHECK_EN to add the ov_err port and
// the per-channel gray step checker.
module gray_codec_pipe
  import gray_codec_pkg::*;
#(
  parameter int          DATA_WIDTH  = 8,
  parameter int          CHANNELS    = 1,
  parameter              MODE        = "B2G",
  parameter logic [31:0] RESET_VALUE = 32'd0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0] iv_data,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0] ov_data
`ifdef GRAY_CODEC_CHECK_EN
  ,
  output logic [CHANNELS-1:0]            ov_err
`endif
);

  localparam int                    BUS_W      = CHANNELS * DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] RESET_WORD = RESET_VALUE[DATA_WIDTH-1:0];

  // Reject illegal configurations at elaboration.
  if (MODE != MODE_B2G && MODE != MODE_G2B) begin : g_bad_mode
    $error("gray_codec_pipe: MODE must be \"B2G\" or \"G2B\"");
  end
  if (DATA_WIDTH < 2 || DATA_WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("gray_codec_pipe: DATA_WIDTH must be in 2..32");
  end
  if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
    $error("gray_codec_pipe: CHANNELS must be in 1..8");
  end

  logic             s1_valid;
  logic [BUS_W-1:0] s1_data;
  logic [BUS_W-1:0] conv_data;
  logic             s2_ready;
  logic             accept;
  logic             advance;

  // S2 can take a word when it is empty or is draining this cycle. S1 can
  // take a word when it is empty or is moving into S2.
  assign s2_ready = !o_valid || i_ready;
  assign o_ready  = !s1_valid || !o_valid || i_ready;
  assign accept   = i_valid && o_ready;
  assign advance  = s1_valid && s2_ready;

  // Advance the valid flags of both stages; reset empties the pipeline.
  // NOTE: reset is synchronous and active-low, so it is tested only inside
  // the clocked block and is never in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      o_valid  <= 1'b0;
    end else begin
      if (o_ready) begin
        s1_valid <= i_valid;
      end
      if (s2_ready) begin
        o_valid <= s1_valid;
      end
    end
  end

  // Capture the input word into S1 on every accepted handshake.
  // NOTE: S1 data is qualified by s1_valid, so it has no reset; only
  // registers whose value is observable after reset are reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_data <= iv_data;
    end
  end

  // Load the converted word into S2 and hold it while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ov_data <= {CHANNELS{RESET_WORD}};
    end else if (advance) begin
      ov_data <= conv_data;
    end
  end

  // One independent conversion lane per channel.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    gray_codec_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .MODE      (MODE)
    ) u_lane (
`ifdef GRAY_CODEC_CHECK_EN
      .clk      (clk),
      .reset_n  (reset_n),
      .accept   (accept),
      .in_word  (iv_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .err      (ov_err[c]),
`endif
      .s1_word  (s1_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .conv_word(conv_data[c*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule : gray_codec_pipe

// File: tb/tb_gray_codec_pipe.sv
// tb_gray_codec_pipe -- scoreboard bench for gray_codec_pipe.
// Two instances (B2G and G2B, 8-bit words, 2 channels, RESET_VALUE 0x5A)
// share the same stimulus. Every accepted word pushes its expected result
// into a per-instance queue. A negedge monitor pops the queue on each output
// handshake and compares. Define GRAY_CODEC_CHECK_EN to model ov_err as well.
module tb_gray_codec_pipe;

  localparam int          W  = 8;
  localparam int          C  = 2;
  localparam int          BW = W * C;
  localparam logic [31:0] RV = 32'h5A;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_ready = 1'b0;
  logic [BW-1:0] iv_data = '0;
  logic          b_o_ready, b_o_valid, g_o_ready, g_o_valid;
  logic [BW-1:0] b_ov, g_ov;
`ifdef GRAY_CODEC_CHECK_EN
  logic [C-1:0]  b_err, g_err;
`endif

  always #5 clk = ~clk;

  gray_codec_pipe #(.DATA_WIDTH(W), .CHANNELS(C), .MODE("B2G"), .RESET_VALUE(RV)) u_b2g (
    .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .o_ready(b_o_ready),
    .iv_data(iv_data), .o_valid(b_o_valid), .i_ready(i_ready), .ov_data(b_ov)
`ifdef GRAY_CODEC_CHECK_EN
    , .ov_err(b_err)
`endif
  );

  gray_codec_pipe #(.DATA_WIDTH(W), .CHANNELS(C), .MODE("G2B"), .RESET_VALUE(RV)) u_g2b (
    .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .o_ready(g_o_ready),
    .iv_data(iv_data), .o_valid(g_o_valid), .i_ready(i_ready), .ov_data(g_ov)
`ifdef GRAY_CODEC_CHECK_EN
    , .ov_err(g_err)
`endif
  );

  int total = 0;
  int bad   = 0;
  logic [BW-1:0] q_b2g[$];
  logic [BW-1:0] q_g2b[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: gray is the word XORed with itself shifted by one.
  function automatic logic [W-1:0] ref_b2g(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Reference: binary is the XOR of all right shifts of the gray word.
  function automatic logic [W-1:0] ref_g2b(input logic [W-1:0] g);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < W; k++) r = r ^ (g >> k);
    return r;
  endfunction

  function automatic logic [BW-1:0] ref_bus(input logic [BW-1:0] d, input bit to_bin);
    logic [BW-1:0] r;
    r = '0;
    for (int c = 0; c < C; c++) begin
      r[c*W +: W] = to_bin ? ref_g2b(d[c*W +: W]) : ref_b2g(d[c*W +: W]);
    end
    return r;
  endfunction

`ifdef GRAY_CODEC_CHECK_EN
  logic [W-1:0] hist[2][C];
  bit           have[2][C];
  logic [C-1:0] err_m[2];

  task automatic err_model_accept(input logic [BW-1:0] d);
    logic [W-1:0] g;
    for (int u = 0; u < 2; u++) begin
      for (int c = 0; c < C; c++) begin
        g = (u == 0) ? ref_b2g(d[c*W +: W]) : d[c*W +: W];
        if (have[u][c] && $countones(hist[u][c] ^ g) > 1) err_m[u][c] = 1'b1;
        have[u][c] = 1'b1;
        hist[u][c] = g;
      end
    end
  endtask
`endif

  task automatic clear_model();
    q_b2g.delete();
    q_g2b.delete();
`ifdef GRAY_CODEC_CHECK_EN
    for (int u = 0; u < 2; u++) begin
      err_m[u] = '0;
      for (int c = 0; c < C; c++) have[u][c] = 1'b0;
    end
`endif
  endtask

  // Monitor and scoreboard: evaluate the handshakes due at the next rising edge.
  always @(negedge clk) begin
    if (reset_n) begin
`ifdef GRAY_CODEC_CHECK_EN
      check("b2g_err", b_err, err_m[0]);
      check("g2b_err", g_err, err_m[1]);
`endif
      if (b_o_valid && i_ready) begin
        check("b2g_out_expected", q_b2g.size() != 0, 1);
        if (q_b2g.size() != 0) check("b2g_data", b_ov, q_b2g.pop_front());
      end
      if (g_o_valid && i_ready) begin
        check("g2b_out_expected", q_g2b.size() != 0, 1);
        if (q_g2b.size() != 0) check("g2b_data", g_ov, q_g2b.pop_front());
      end
      if (i_valid && b_o_ready) q_b2g.push_back(ref_bus(iv_data, 1'b0));
      if (i_valid && g_o_ready) q_g2b.push_back(ref_bus(iv_data, 1'b1));
`ifdef GRAY_CODEC_CHECK_EN
      if (i_valid && g_o_ready) err_model_accept(iv_data);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [BW-1:0] snap;
  int            waited;

  initial begin
    clear_model();
    reset_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (3) step();

    // Reset state.
    check("rst_b2g_valid", b_o_valid, 0);
    check("rst_g2b_valid", g_o_valid, 0);
    check("rst_b2g_data", b_ov, 16'h5A5A);
    check("rst_g2b_data", g_ov, 16'h5A5A);
    reset_n = 1'b1;
    check("rel_b2g_ready", b_o_ready, 1);
    check("rel_g2b_ready", g_o_ready, 1);

    // Single word into an empty pipe: output appears exactly two edges later.
    i_valid = 1'b1;
    iv_data = 16'h0C08;
    step();
    i_valid = 1'b0;
    check("lat1_b2g_valid", b_o_valid, 0);
    check("lat1_g2b_valid", g_o_valid, 0);
    step();
    check("lat2_b2g_valid", b_o_valid, 1);
    check("lat2_g2b_valid", g_o_valid, 1);
    check("lat2_b2g_data", b_ov, 16'h0A0C);
    check("lat2_g2b_data", g_ov, 16'h080F);
    repeat (2) step();

    // Full sweep of channel 0 at full throughput.
    for (int i = 0; i < 256; i++) begin
      if (i >= 2) begin
        check("sweep_b2g_valid", b_o_valid, 1);
        check("sweep_b2g_ready", b_o_ready, 1);
      end
      i_valid = 1'b1;
      iv_data = {8'($urandom), 8'(i)};
      step();
    end
    i_valid = 1'b0;
    repeat (3) step();

    // Backpressure: two words fill the pipe, then input stalls and output holds.
    i_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      check("bp_b2g_ready", b_o_ready, (k < 2) ? 1 : 0);
      check("bp_g2b_ready", g_o_ready, (k < 2) ? 1 : 0);
      if (k == 2) snap = b_ov;
      if (k > 2) check("bp_b2g_hold", b_ov, snap);
      if (k >= 2) check("bp_b2g_valid", b_o_valid, 1);
      i_valid = 1'b1;
      iv_data = 16'($urandom);
      step();
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (4) step();

    // Reset with two words in flight: both are discarded.
    i_ready = 1'b0;
    i_valid = 1'b1;
    iv_data = 16'h1234;
    step();
    iv_data = 16'h5678;
    step();
    i_valid = 1'b0;
    check("fill_b2g_valid", b_o_valid, 1);
    reset_n = 1'b0;
    clear_model();
    step();
    check("midrst_b2g_valid", b_o_valid, 0);
    check("midrst_g2b_valid", g_o_valid, 0);
    check("midrst_b2g_data", b_ov, 16'h5A5A);
    check("midrst_g2b_data", g_ov, 16'h5A5A);
    check("midrst_b2g_ready", b_o_ready, 1);
    reset_n = 1'b1;
    i_ready = 1'b1;
    check("midrst_rel_ready", g_o_ready, 1);
    repeat (4) step();

`ifdef GRAY_CODEC_CHECK_EN
    // Step checker: channel 0 gray steps 0,1,3,0 (last is two bits), channel 1 steady.
    for (int k = 0; k < 4; k++) begin
      i_valid = 1'b1;
      iv_data = {8'h22, (k == 1) ? 8'h01 : (k == 2) ? 8'h03 : 8'h00};
      step();
      check("step_g2b_err", g_err, (k == 3) ? 2'b01 : 2'b00);
    end
    i_valid = 1'b0;
    repeat (3) step();
    check("step_g2b_sticky", g_err, 2'b01);
`endif

    // Random valid/ready toggling.
    for (int n = 0; n < 10000; n++) begin
      i_valid = ($urandom_range(3) != 0);
      i_ready = ($urandom_range(2) != 0);
      iv_data = 16'($urandom);
      step();
    end

    // Drain with a bounded wait.
    i_valid = 1'b0;
    i_ready = 1'b1;
    waited  = 0;
    while ((q_b2g.size() != 0 || q_g2b.size() != 0) && waited < 20) begin
      step();
      waited++;
    end
    check("drain_b2g_left", q_b2g.size(), 0);
    check("drain_g2b_left", q_g2b.size(), 0);
    check("drain_b2g_valid", b_o_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_gray_codec_pipe
